pin_entry_unit: RTL and testbench
=================================

PIN_ENTRY_UNIT -- requirements
Module: pin_entry_unit

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 16'd1000, idle cycles before partial entry is discarded (legal 1..65535).
REQ-002 Parameter CLAVE_REPOSO, default 16'hFFFF, value driven on clave_ingresada when no PIN is presented (non-BCD, so it never matches a valid PIN).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low.
REQ-005 sensor_llegada_vehiculo  input  1  vehicle present at entry; enables keypad.
REQ-006 tecla_valida  input  1  one-cycle key strobe.
REQ-007 tecla_codigo  input  4  key code: 0x0-0x9 digit, 0xA clear, 0xB enter, 0xC-0xF invalid.
REQ-008 clave_ingresada  output  16  last submitted PIN, 4 BCD digits, first digit in [15:12]; feeds access controller.
REQ-009 clave_lista  output  1  one-cycle pulse, clave_ingresada newly loaded.
REQ-010 digitos  output  3  digits held in entry buffer (0..4).
REQ-011 error_tecla  output  1  one-cycle pulse, key rejected.
REQ-012 timeout_entrada  output  1  one-cycle pulse, partial entry discarded on inactivity.

Function
REQ-013 All outputs are registered; every response appears the cycle after the causing input edge.
REQ-014 States: INACTIVO, CAPTURA, LLENO, ENVIADO; internal 16-bit buffer and 3-bit digit count are separate from clave_ingresada.
REQ-015 INACTIVO: keys ignored with no error pulse; sensor_llegada_vehiculo=1 -> CAPTURA with buffer=0, digitos=0.
REQ-016 Any state, sensor_llegada_vehiculo=0 -> INACTIVO, buffer=0, digitos=0, clave_ingresada=CLAVE_REPOSO; this overrides any same-cycle key.
REQ-017 CAPTURA digit: buffer={buffer[11:0],digit}, digitos+1; at digitos=4 -> LLENO.
REQ-018 CAPTURA clear: buffer=0, digitos=0, stay CAPTURA; enter with digitos<4: error_tecla pulse, buffer and digitos cleared.
REQ-019 LLENO digit: ignored, error_tecla pulse; clear -> CAPTURA, buffer and digitos cleared.
REQ-020 LLENO enter: clave_ingresada=buffer, clave_lista pulse, buffer and digitos cleared -> ENVIADO.
REQ-021 ENVIADO: clave_ingresada held; digit -> CAPTURA with buffer={12'h000,digit}, digitos=1, clave_ingresada=CLAVE_REPOSO; clear -> CAPTURA, clave_ingresada=CLAVE_REPOSO; enter ignored, no pulse.
REQ-022 Codes 0xC-0xF in CAPTURA, LLENO, ENVIADO: ignored, error_tecla pulse, no state change.
REQ-023 tecla_valida=0: tecla_codigo ignored.
REQ-024 Only ENVIADO drives a value other than CLAVE_REPOSO on clave_ingresada.

Reset
REQ-025 reset=0 at a clock edge, regardless of state: INACTIVO, buffer=0, digitos=0, timeout counter=0, clave_ingresada=CLAVE_REPOSO, clave_lista=0, error_tecla=0, timeout_entrada=0.
REQ-026 Reset mid-entry or during ENVIADO discards all digits and any pending pulse.

Configuration
REQ-027 Macro PIN_TIMEOUT_EN defined: 16-bit idle counter runs in CAPTURA and LLENO while digitos>0.
REQ-028 Counter clears on any accepted key (digit, clear, enter) or on leaving those states; a key in the same cycle as expiry wins.
REQ-029 On reaching TIMEOUT_CICLOS: buffer and digitos cleared, timeout_entrada pulse, state CAPTURA.
REQ-030 Macro PIN_TIMEOUT_EN undefined: no counter; timeout_entrada tied 0; partial entries persist indefinitely.

Verification
REQ-031 sensor=1; keys 2,4,6,8,enter -> clave_ingresada=16'h2468, one clave_lista pulse, digitos returns 0, state ENVIADO.
REQ-032 Keys 1,2,enter -> error_tecla pulse, digitos=0, clave_ingresada stays 16'hFFFF.
REQ-033 Keys 1,2,3,4,5 -> error_tecla on the 5th key; enter -> clave_ingresada=16'h1234.
REQ-034 In ENVIADO with 16'h2468, key 7 -> clave_ingresada=16'hFFFF, digitos=1; sensor drop with key on same cycle -> INACTIVO, digitos=0, no error.
REQ-035 PIN_TIMEOUT_EN, TIMEOUT_CICLOS=10: key 9 then 10 idle cycles -> timeout_entrada pulse, digitos=0; rerun undefined -> no pulse, digitos stays 1.
REQ-036 reset=0 asserted after keys 3,3 -> all outputs at reset values next cycle; code 0xE -> error_tecla only.

Source files
------------

// File: rtl/pin_entry_unit.sv
// Keypad PIN capture for the vehicle entry gate.
// Optional idle timeout when PIN_TIMEOUT_EN is defined.
module pin_entry_unit #(
  parameter logic [15:0] TIMEOUT_CICLOS = 16'd1000,
  parameter logic [15:0] CLAVE_REPOSO   = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sensor_llegada_vehiculo,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla_codigo,
  output logic [15:0] clave_ingresada,
  output logic        clave_lista,
  output logic [2:0]  digitos,
  output logic        error_tecla,
  output logic        timeout_entrada
);

  typedef enum logic [1:0] {
    INACTIVO,
    CAPTURA,
    LLENO,
    ENVIADO
  } estado_t;

  estado_t     estado;
  logic [15:0] buffer;

  logic es_digito;
  logic es_borrar;
  logic es_enter;
  logic es_invalida;
  logic aceptada;
  logic expira;

  assign es_digito   = tecla_valida && (tecla_codigo <= 4'h9);
  assign es_borrar   = tecla_valida && (tecla_codigo == 4'hA);
  assign es_enter    = tecla_valida && (tecla_codigo == 4'hB);
  assign es_invalida = tecla_valida && (tecla_codigo >= 4'hC);
  assign aceptada    = es_digito || es_borrar || es_enter;

`ifdef PIN_TIMEOUT_EN
  logic [15:0] ocioso;
  logic        corre;

  // Counts only idle cycles while a partial entry is held
  assign corre  = ((estado == CAPTURA) || (estado == LLENO))
               && (digitos != 3'd0) && !aceptada;
  assign expira = corre
               && (({1'b0, ocioso} + 17'd1) == {1'b0, TIMEOUT_CICLOS});

  always_ff @(posedge clock) begin
    if (!reset) begin
      ocioso          <= 16'd0;
      timeout_entrada <= 1'b0;
    end else begin
      timeout_entrada <= sensor_llegada_vehiculo && expira;
      if (!sensor_llegada_vehiculo || !corre || expira)
        ocioso <= 16'd0;
      else
        ocioso <= ocioso + 16'd1;
    end
  end
`else
  wire unused_timeout = ^TIMEOUT_CICLOS;
  assign expira          = 1'b0;
  assign timeout_entrada = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado          <= INACTIVO;
      buffer          <= 16'd0;
      digitos         <= 3'd0;
      clave_ingresada <= CLAVE_REPOSO;
      clave_lista     <= 1'b0;
      error_tecla     <= 1'b0;
    end else begin
      clave_lista <= 1'b0;
      error_tecla <= 1'b0;
      if (!sensor_llegada_vehiculo) begin
        estado          <= INACTIVO;
        buffer          <= 16'd0;
        digitos         <= 3'd0;
        clave_ingresada <= CLAVE_REPOSO;
      end else begin
        unique case (estado)
          INACTIVO: begin
            estado  <= CAPTURA;
            buffer  <= 16'd0;
            digitos <= 3'd0;
          end
          CAPTURA: begin
            unique case (1'b1)
              es_digito: begin
                buffer  <= {buffer[11:0], tecla_codigo};
                digitos <= digitos + 3'd1;
                if (digitos == 3'd3)
                  estado <= LLENO;
              end
              es_borrar: begin
                buffer  <= 16'd0;
                digitos <= 3'd0;
              end
              es_enter: begin
                error_tecla <= 1'b1;
                buffer      <= 16'd0;
                digitos     <= 3'd0;
              end
              es_invalida: error_tecla <= 1'b1;
              default: ;
            endcase
          end
          LLENO: begin
            unique case (1'b1)
              es_digito: error_tecla <= 1'b1;
              es_borrar: begin
                estado  <= CAPTURA;
                buffer  <= 16'd0;
                digitos <= 3'd0;
              end
              es_enter: begin
                clave_ingresada <= buffer;
                clave_lista     <= 1'b1;
                buffer          <= 16'd0;
                digitos         <= 3'd0;
                estado          <= ENVIADO;
              end
              es_invalida: error_tecla <= 1'b1;
              default: ;
            endcase
          end
          ENVIADO: begin
            unique case (1'b1)
              es_digito: begin
                estado          <= CAPTURA;
                buffer          <= {12'h000, tecla_codigo};
                digitos         <= 3'd1;
                clave_ingresada <= CLAVE_REPOSO;
              end
              es_borrar: begin
                estado          <= CAPTURA;
                buffer          <= 16'd0;
                digitos         <= 3'd0;
                clave_ingresada <= CLAVE_REPOSO;
              end
              es_invalida: error_tecla <= 1'b1;
              default: ;
            endcase
          end
          default: estado <= INACTIVO;
        endcase
        // Expiry never coincides with an accepted key
        if (expira) begin
          estado  <= CAPTURA;
          buffer  <= 16'd0;
          digitos <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pin_entry_unit.sv
// Self-checking bench for pin_entry_unit.
// Directed scenarios plus random keys against a digit-queue model.
module tb_pin_entry_unit;

  localparam logic [15:0] T      = 16'd10;
  localparam logic [15:0] REPOSO = 16'hFFFF;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic        sensor = 1'b0;
  logic        valid  = 1'b0;
  logic [3:0]  code   = 4'h0;
  logic [15:0] clave;
  logic        lista;
  logic [2:0]  digitos;
  logic        err;
  logic        tout;

  int total = 0;
  int bad   = 0;

  bit          m_act;
  bit          m_sent;
  int          m_q[$];
  logic [15:0] m_pin = REPOSO;
  int          m_idle;
  bit          m_lista;
  bit          m_err;
  bit          m_to;

  pin_entry_unit #(
    .TIMEOUT_CICLOS(T),
    .CLAVE_REPOSO(REPOSO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sensor_llegada_vehiculo(sensor),
    .tecla_valida(valid),
    .tecla_codigo(code),
    .clave_ingresada(clave),
    .clave_lista(lista),
    .digitos(digitos),
    .error_tecla(err),
    .timeout_entrada(tout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] q_val();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return v[15:0];
  endfunction

  task automatic model_step();
    bit acc;
    int k;
    m_lista = 0;
    m_err   = 0;
    m_to    = 0;
    k   = int'(code);
    acc = valid && (k <= 11);
    if (!reset || !sensor) begin
      m_act  = 0;
      m_sent = 0;
      m_q.delete();
      m_pin  = REPOSO;
      m_idle = 0;
    end else if (!m_act) begin
      m_act  = 1;
      m_sent = 0;
      m_q.delete();
      m_idle = 0;
    end else begin
      if (valid && k >= 12) m_err = 1;
      if (!acc) begin
        if (m_q.size() > 0) begin
`ifdef PIN_TIMEOUT_EN
          m_idle++;
          if (m_idle == int'(T)) begin
            m_q.delete();
            m_to   = 1;
            m_idle = 0;
          end
`endif
        end else m_idle = 0;
      end else begin
        m_idle = 0;
        if (m_sent) begin
          if (k <= 9) begin
            m_sent = 0;
            m_q.delete();
            m_q.push_back(k);
            m_pin = REPOSO;
          end else if (k == 10) begin
            m_sent = 0;
            m_pin  = REPOSO;
          end
        end else if (k <= 9) begin
          if (m_q.size() < 4) m_q.push_back(k);
          else m_err = 1;
        end else if (k == 10) begin
          m_q.delete();
        end else begin
          if (m_q.size() == 4) begin
            m_pin   = q_val();
            m_lista = 1;
            m_sent  = 1;
          end else m_err = 1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic cyc(input bit s, input bit v, input logic [3:0] c);
    sensor = s;
    valid  = v;
    code   = c;
    @(posedge clock);
    model_step();
    #1;
    check("clave", clave, m_pin);
    check("lista", {15'b0, lista}, {15'b0, m_lista});
    check("digitos", {13'b0, digitos}, 16'(m_q.size()));
    check("error", {15'b0, err}, {15'b0, m_err});
    check("timeout", {15'b0, tout}, {15'b0, m_to});
  endtask

  task automatic key(input logic [3:0] c);
    cyc(1, 1, c);
  endtask

  initial begin
    reset = 0;
    cyc(0, 0, 4'h0);
    cyc(1, 1, 4'h3);
    check("rst_clave", clave, 16'hFFFF);
    check("rst_digitos", {13'b0, digitos}, 16'd0);
    reset = 1;
    cyc(1, 0, 4'h0);

    key(4'h2); key(4'h4); key(4'h6); key(4'h8);
    check("full_digitos", {13'b0, digitos}, 16'd4);
    key(4'hB);
    check("pin_2468", clave, 16'h2468);
    check("pin_lista", {15'b0, lista}, 16'd1);
    check("pin_digitos", {13'b0, digitos}, 16'd0);
    cyc(1, 0, 4'h0);
    check("lista_once", {15'b0, lista}, 16'd0);
    key(4'hB);
    check("sent_enter", clave, 16'h2468);

    key(4'h7);
    check("sent_digit_clave", clave, 16'hFFFF);
    check("sent_digit_n", {13'b0, digitos}, 16'd1);
    cyc(0, 1, 4'h5);
    check("drop_digitos", {13'b0, digitos}, 16'd0);
    check("drop_err", {15'b0, err}, 16'd0);
    cyc(1, 0, 4'h0);

    key(4'h1); key(4'h2); key(4'hB);
    check("short_err", {15'b0, err}, 16'd1);
    check("short_n", {13'b0, digitos}, 16'd0);
    check("short_clave", clave, 16'hFFFF);

    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
    check("fifth_err", {15'b0, err}, 16'd1);
    key(4'hB);
    check("pin_1234", clave, 16'h1234);

    key(4'h9);
    check("to_start", {13'b0, digitos}, 16'd1);
    for (int i = 0; i < int'(T); i++) cyc(1, 0, 4'h0);
`ifdef PIN_TIMEOUT_EN
    check("to_pulse", {15'b0, tout}, 16'd1);
    check("to_digitos", {13'b0, digitos}, 16'd0);
`else
    check("to_pulse", {15'b0, tout}, 16'd0);
    check("to_digitos", {13'b0, digitos}, 16'd1);
`endif

    key(4'hA);
    key(4'h3); key(4'h3);
    reset = 0;
    cyc(1, 0, 4'h0);
    check("mid_rst_n", {13'b0, digitos}, 16'd0);
    check("mid_rst_clave", clave, 16'hFFFF);
    reset = 1;
    cyc(1, 0, 4'h0);
    key(4'hE);
    check("bad_code_err", {15'b0, err}, 16'd1);
    check("bad_code_n", {13'b0, digitos}, 16'd0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] c;
      reset = ($urandom_range(0, 299) != 0);
      r = $urandom_range(0, 99);
      if (r < 60) c = 4'($urandom_range(0, 9));
      else if (r < 72) c = 4'hA;
      else if (r < 90) c = 4'hB;
      else c = 4'($urandom_range(12, 15));
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
